glb_mif_rsp: RTL and testbench
==============================

# glb_mif_rsp

Responder side of the pooling memory-interface read protocol. It sits in the GLB and serves POOL_CORE independent address/data port pairs driven by the pooling memory interface. Each cycle it arbitrates the pending addresses round-robin onto one shared single-port SRAM read, then steers the returned word into a per-port output FIFO. Each FIFO drains under its own valid/ready handshake.

## Interface
- POOL_CORE, 6, number of port pairs (≥2)
- POOL_COMP_CORE, 64, activations per returned word
- ACT_WIDTH, 8, bits per activation
- IDX_WIDTH, 10, SRAM word address width
- FIFO_DEPTH, 3, per-port output FIFO entries (≥2)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- MIFGLB_AddrVld  in  POOL_CORE  per-port address valid
- MIFGLB_Addr  in  IDX_WIDTH*POOL_CORE  per-port address; port i at [IDX_WIDTH*i +: IDX_WIDTH]
- GLBMIF_AddrRdy  out  POOL_CORE  per-port address accept
- GLBRAM_RdEn  out  1  SRAM read enable
- GLBRAM_RdAddr  out  IDX_WIDTH  SRAM read address
- RAMGLB_RdDat  in  ACT_WIDTH*POOL_COMP_CORE  SRAM read data, valid exactly one cycle after RdEn
- GLBMIF_Ofm  out  ACT_WIDTH*POOL_COMP_CORE*POOL_CORE  per-port data word (FIFO head)
- GLBMIF_OfmVld  out  POOL_CORE  per-port data valid
- MIFGLB_OfmRdy  in  POOL_CORE  per-port data ready

## Operation
- **Eligibility:** elig[i] = AddrVld[i] & (cnt[i] + infl[i] < FIFO_DEPTH).
  - cnt[i] is FIFO occupancy; infl[i] is 1 when the SRAM read issued last cycle belongs to port i.
  - Eligibility does not include the same-cycle pop, so there is no combinational path from OfmRdy to AddrRdy.
- **Arbitration:** round-robin over elig.
  - Search starts at pointer ptr and wraps modulo POOL_CORE; grant is one-hot.
  - ptr resets to 0. On a grant to port g, ptr ← (g+1) mod POOL_CORE. With no grant, ptr holds.
- **Address handshake:** GLBMIF_AddrRdy = grant (combinational). A handshake occurs when AddrVld[i] & AddrRdy[i].
- **SRAM issue:** in the handshake cycle, GLBRAM_RdEn = |grant and GLBRAM_RdAddr = Addr of the granted port. With no grant, GLBRAM_RdAddr = 0.
- **In-flight register:** on the next edge it captures {vld = |grant, id = granted index}.
- **Return:** in the cycle after issue, RAMGLB_RdDat is written into FIFO[id] if vld. Returned data is always accepted; capacity is reserved by eligibility.
- **FIFO:** one per port, FIFO_DEPTH entries, first-in first-out.
  - Pop when OfmVld[i] & OfmRdy[i].
  - Simultaneous push and pop leaves cnt unchanged and keeps data order correct, including push into a FIFO of count 1 being popped.
  - GLBMIF_OfmVld[i] = (cnt[i] != 0).
  - GLBMIF_Ofm slice i = head entry. It is held stable while Vld & !Rdy.
- **Ordering:** per-port responses come back in address-acceptance order. There is no ordering guarantee across ports.
- **Overflow/underflow:** unreachable by construction. The bench asserts that cnt never exceeds FIFO_DEPTH and never pops when empty.

## Timing
- **Reset values:**
  - Outputs: GLBMIF_AddrRdy=0, GLBRAM_RdEn=0, GLBRAM_RdAddr=0, GLBMIF_OfmVld=0, GLBMIF_Ofm=0.
  - Internal state: all cnt, in-flight vld and ptr cleared.
- **Reset priority:** rst has priority over every same-edge event.
- **Reset mid-operation:**
  - FIFOs are flushed and in-flight vld is cleared.
  - SRAM data returning in the cycle after reset release is dropped.
- **Latency:** address handshake in cycle T gives SRAM data in T+1, FIFO write at the end of T+1, and OfmVld in T+2 (when the FIFO was empty).
- **Throughput:** with FIFO_DEPTH=3 and OfmRdy held high, a single port sustains one word per cycle. The aggregate rate is one read per cycle across all ports.
- **Backpressure:** with OfmRdy=0, a port accepts exactly FIFO_DEPTH addresses, then AddrRdy[i] stays 0 until a pop occurs. The first new accept is possible in the cycle after that pop.

## Test plan
- **Reset:**
  - Stimulus: hold rst 3 cycles with all AddrVld=1.
  - Required: all outputs 0. After release, port 0 is granted first and the grant order is 0,1,2,3,4,5,0.
- **Single read:**
  - Stimulus: port 2, Addr=0x155, accepted at T; SRAM model returns word 0x155-tagged; OfmRdy=1.
  - Required: RdEn/RdAddr=0x155 at T. OfmVld[2] high only at T+2 with the tagged word. No other port's Vld asserts.
- **Contention:**
  - Stimulus: all 6 ports valid continuously, distinct addresses, OfmRdy=1.
  - Required: one grant per cycle in round-robin order. Each port receives its words in order at 1/6 rate.
- **Backpressure:**
  - Stimulus: port 0 with 5 addresses queued, OfmRdy[0]=0.
  - Required: exactly 3 accepts, then AddrRdy[0]=0. After OfmRdy[0]=1 for one cycle, the 4th is accepted next cycle. Order is preserved.
- **Streaming:**
  - Stimulus: port 5 alone, 20 back-to-back addresses, OfmRdy=1.
  - Required: 20 consecutive accepts and 20 consecutive OfmVld cycles starting 2 cycles after the first accept.
- **Reset in flight:**
  - Stimulus: assert rst in the cycle after an accept, with 2 entries already queued in port 1.
  - Required: after release, OfmVld[1]=0 and the returned SRAM word is discarded.

Source files
------------

// File: rtl/glb_mif_rsp.sv
// GLB responder for the pooling memory-interface read protocol: round-robin arbitration of
// POOL_CORE address ports onto one SRAM read, with returned words steered into per-port FIFOs.
module glb_mif_rsp #(
  parameter int POOL_CORE      = 6,
  parameter int POOL_COMP_CORE = 64,
  parameter int ACT_WIDTH      = 8,
  parameter int IDX_WIDTH      = 10,
  parameter int FIFO_DEPTH     = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [POOL_CORE-1:0]                            MIFGLB_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]                  MIFGLB_Addr,
  output logic [POOL_CORE-1:0]                            GLBMIF_AddrRdy,
  output logic                                            GLBRAM_RdEn,
  output logic [IDX_WIDTH-1:0]                            GLBRAM_RdAddr,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0]             RAMGLB_RdDat,
  output logic [ACT_WIDTH*POOL_COMP_CORE*POOL_CORE-1:0]   GLBMIF_Ofm,
  output logic [POOL_CORE-1:0]                            GLBMIF_OfmVld,
  input  logic [POOL_CORE-1:0]                            MIFGLB_OfmRdy
);

  localparam int WORD_W = ACT_WIDTH * POOL_COMP_CORE;
  localparam int ID_W   = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FP_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ID_W-1:0]      ptr_reg, ptr_next;
  logic [POOL_CORE-1:0] elig;
  logic [POOL_CORE-1:0] grant;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_idx;
  logic [IDX_WIDTH-1:0] rd_addr;
  logic                 infl_vld_reg;
  logic [ID_W-1:0]      infl_id_reg;

  // Round-robin search starting at ptr_reg; the first eligible port wins.
  always_comb begin : arb
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < POOL_CORE; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= POOL_CORE) idx = idx - POOL_CORE;
      if (!grant_any && elig[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any)
      ptr_next = (grant_idx == ID_W'(POOL_CORE - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < POOL_CORE; i++)
      if (grant[i]) rd_addr = MIFGLB_Addr[IDX_WIDTH*i +: IDX_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      infl_vld_reg <= 1'b0;
      infl_id_reg  <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      infl_vld_reg <= grant_any;
      infl_id_reg  <= grant_idx;
    end
  end

  assign GLBMIF_AddrRdy = grant;
  assign GLBRAM_RdEn    = grant_any;
  assign GLBRAM_RdAddr  = rd_addr;

  generate
    for (genvar gi = 0; gi < POOL_CORE; gi++) begin : g_port
      logic [WORD_W-1:0] mem [FIFO_DEPTH];
      logic [FP_W-1:0]   wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              push, pop;
      logic [CNT_W:0]    occ;

      // The read returning this cycle already owns a slot, so it counts toward occupancy.
      assign push     = infl_vld_reg && (infl_id_reg == ID_W'(gi));
      assign pop      = (cnt_reg != '0) && MIFGLB_OfmRdy[gi];
      assign occ      = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, push};
      assign elig[gi] = MIFGLB_AddrVld[gi] && !rst && (occ < (CNT_W+1)'(FIFO_DEPTH));

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg    <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push)
            wr_ptr_reg <= (wr_ptr_reg == FP_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + FP_W'(1);
          if (pop)
            rd_ptr_reg <= (rd_ptr_reg == FP_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + FP_W'(1);
          if (push && !pop)
            cnt_reg <= cnt_reg + CNT_W'(1);
          else if (!push && pop)
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

      // Head is read combinationally so a push lands on OfmVld the very next cycle.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= RAMGLB_RdDat;
      end

      assign GLBMIF_OfmVld[gi]               = (cnt_reg != '0);
      assign GLBMIF_Ofm[WORD_W*gi +: WORD_W] = (cnt_reg != '0) ? mem[rd_ptr_reg] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_glb_mif_rsp.sv
// Directed bench for glb_mif_rsp: vector table for reset/arbitration/single read, hand-written
// sequences for contention, backpressure, streaming and reset in flight, plus a per-port scoreboard.
module tb_glb_mif_rsp;
  localparam int PC = 6;
  localparam int CC = 64;
  localparam int AW = 8;
  localparam int IW = 10;
  localparam int FD = 3;
  localparam int WW = AW * CC;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC-1:0]     addr_vld, addr_rdy, ofm_vld, ofm_rdy;
  logic [IW*PC-1:0]  addr_bus;
  logic              rd_en;
  logic [IW-1:0]     rd_addr;
  logic [WW-1:0]     rd_dat = '0;
  logic [WW*PC-1:0]  ofm;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  glb_mif_rsp #(
    .POOL_CORE(PC), .POOL_COMP_CORE(CC), .ACT_WIDTH(AW), .IDX_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .MIFGLB_AddrVld(addr_vld), .MIFGLB_Addr(addr_bus), .GLBMIF_AddrRdy(addr_rdy),
    .GLBRAM_RdEn(rd_en), .GLBRAM_RdAddr(rd_addr), .RAMGLB_RdDat(rd_dat),
    .GLBMIF_Ofm(ofm), .GLBMIF_OfmVld(ofm_vld), .MIFGLB_OfmRdy(ofm_rdy)
  );

  function automatic logic [WW-1:0] tag(input logic [IW-1:0] a);
    return {32{a, 6'h15}};
  endfunction

  // SRAM model: one-cycle read latency, junk when not enabled.
  always @(posedge clk) rd_dat <= rd_en ? tag(rd_addr) : {WW{1'b1}};

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: per-port queue of accepted addresses, checked against popped words.
  logic [IW-1:0] q [PC][$];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < PC; i++) q[i].delete();
    end else begin
      for (int i = 0; i < PC; i++) begin
        chk($sformatf("sb.outstanding%0d", i), WW'(q[i].size() <= FD), 1);
        if (ofm_vld[i] && ofm_rdy[i]) begin
          chk($sformatf("sb.pop_nonempty%0d", i), WW'(q[i].size() != 0), 1);
          if (q[i].size() != 0) begin
            chk($sformatf("sb.data%0d", i), ofm[WW*i +: WW], tag(q[i][0]));
            $display("t=%0t port %0d returned word for addr %03h", $time, i, q[i][0]);
            void'(q[i].pop_front());
          end
        end
        if (addr_vld[i] && addr_rdy[i]) q[i].push_back(addr_bus[IW*i +: IW]);
      end
    end
  end

  typedef struct {
    logic          rst;
    logic [PC-1:0] vld;
    logic [PC-1:0] rdy;
    logic [IW*PC-1:0] bus;
    logic [PC-1:0] e_addr_rdy;
    logic          e_rden;
    logic [IW-1:0] e_rdaddr;
    logic [PC-1:0] e_ofm_vld;
    int            hd_port;
    logic [IW-1:0] hd_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic [PC-1:0] v, input logic [PC-1:0] rd,
                     input logic [IW*PC-1:0] b, input logic [PC-1:0] ear, input logic een,
                     input logic [IW-1:0] ead, input logic [PC-1:0] eov,
                     input int hp, input logic [IW-1:0] ha);
    vec_t t;
    t.rst = r; t.vld = v; t.rdy = rd; t.bus = b;
    t.e_addr_rdy = ear; t.e_rden = een; t.e_rdaddr = ead; t.e_ofm_vld = eov;
    t.hd_port = hp; t.hd_addr = ha;
    vecs.push_back(t);
  endtask

  initial begin
    logic [IW*PC-1:0] bus_std, bus_sr;
    int n, eg, nv, first_acc, last_acc, first_v, last_v;
    int seq [PC];

    rst = 1'b1; addr_vld = '0; addr_bus = '0; ofm_rdy = '0;
    for (int i = 0; i < PC; i++) bus_std[IW*i +: IW] = IW'(10'h200 + i * 16);
    bus_sr = '0;
    bus_sr[IW*2 +: IW] = 10'h155;

    // Reset held with every port requesting, then round-robin from port 0.
    for (int r = 0; r < 3; r++) add(1, 6'h3F, 6'h3F, bus_std, 6'h00, 0, 10'h000, 6'h00, -1, 0);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h01, 1, 10'h200, 6'h00, -1, 0);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h02, 1, 10'h210, 6'h00, -1, 0);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h04, 1, 10'h220, 6'h01,  0, 10'h200);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h08, 1, 10'h230, 6'h02,  1, 10'h210);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h10, 1, 10'h240, 6'h04,  2, 10'h220);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h20, 1, 10'h250, 6'h08,  3, 10'h230);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h01, 1, 10'h200, 6'h10,  4, 10'h240);
    add(0, 6'h3F, 6'h3F, bus_std, 6'h02, 1, 10'h210, 6'h20,  5, 10'h250);
    add(0, 6'h00, 6'h3F, bus_std, 6'h00, 0, 10'h000, 6'h01,  0, 10'h200);
    add(0, 6'h00, 6'h3F, bus_std, 6'h00, 0, 10'h000, 6'h02,  1, 10'h210);
    add(0, 6'h00, 6'h3F, bus_std, 6'h00, 0, 10'h000, 6'h00, -1, 0);
    // Single read on port 2.
    add(0, 6'h04, 6'h3F, bus_sr, 6'h04, 1, 10'h155, 6'h00, -1, 0);
    add(0, 6'h00, 6'h3F, bus_sr, 6'h00, 0, 10'h000, 6'h00, -1, 0);
    add(0, 6'h00, 6'h3F, bus_sr, 6'h00, 0, 10'h000, 6'h04,  2, 10'h155);
    add(0, 6'h00, 6'h3F, bus_sr, 6'h00, 0, 10'h000, 6'h00, -1, 0);

    next_cycle();
    foreach (vecs[k]) begin
      rst = vecs[k].rst; addr_vld = vecs[k].vld; ofm_rdy = vecs[k].rdy; addr_bus = vecs[k].bus;
      @(negedge clk);
      chk($sformatf("v%0d.addr_rdy", k), addr_rdy, vecs[k].e_addr_rdy);
      chk($sformatf("v%0d.rd_en", k), rd_en, vecs[k].e_rden);
      chk($sformatf("v%0d.rd_addr", k), rd_addr, vecs[k].e_rdaddr);
      chk($sformatf("v%0d.ofm_vld", k), ofm_vld, vecs[k].e_ofm_vld);
      if (vecs[k].rst) chk($sformatf("v%0d.ofm_nonzero", k), WW'(ofm != '0), 0);
      if (vecs[k].hd_port >= 0)
        chk($sformatf("v%0d.head", k), ofm[WW*vecs[k].hd_port +: WW], tag(vecs[k].hd_addr));
      next_cycle();
    end

    // Contention: all ports, distinct advancing addresses; pointer sits at 3 after port 2's grant.
    for (int i = 0; i < PC; i++) seq[i] = 0;
    eg = 3;
    addr_vld = 6'h3F; ofm_rdy = 6'h3F;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < PC; i++) addr_bus[IW*i +: IW] = IW'(i * 64 + seq[i]);
      @(negedge clk);
      chk($sformatf("cont%0d.grant", c), addr_rdy, WW'(6'h01 << eg));
      chk($sformatf("cont%0d.rd_addr", c), rd_addr, IW'(eg * 64 + seq[eg]));
      if (addr_rdy[eg]) seq[eg]++;
      eg = (eg + 1) % PC;
      next_cycle();
    end
    addr_vld = '0;
    for (int c = 0; c < 4; c++) next_cycle();

    // Backpressure on port 0.
    n = 0; ofm_rdy = 6'h3E; addr_bus = '0;
    for (int c = 0; c < 6; c++) begin
      addr_vld = {5'b0, n < 5}; addr_bus[0 +: IW] = IW'(10'h300 + n);
      @(negedge clk);
      if (c >= 3) chk($sformatf("bp%0d.stall", c), addr_rdy[0], 0);
      if (addr_vld[0] && addr_rdy[0]) n++;
      next_cycle();
    end
    chk("bp.accepts", n, 3);
    ofm_rdy = 6'h3F; addr_bus[0 +: IW] = IW'(10'h300 + n);
    @(negedge clk);
    chk("bp.pop_cycle_rdy", addr_rdy[0], 0);
    chk("bp.pop_head", ofm[0 +: WW], tag(10'h300));
    if (addr_vld[0] && addr_rdy[0]) n++;
    next_cycle();
    ofm_rdy = 6'h3E;
    @(negedge clk);
    chk("bp.fourth_rdy", addr_rdy[0], 1);
    chk("bp.fourth_addr", rd_addr, 10'h303);
    if (addr_vld[0] && addr_rdy[0]) n++;
    next_cycle();
    ofm_rdy = 6'h3F;
    for (int c = 0; c < 10; c++) begin
      addr_vld = {5'b0, n < 5}; addr_bus[0 +: IW] = IW'(10'h300 + n);
      @(negedge clk);
      if (addr_vld[0] && addr_rdy[0]) n++;
      next_cycle();
    end
    chk("bp.total", n, 5);
    addr_vld = '0;
    for (int c = 0; c < 6; c++) next_cycle();

    // Streaming on port 5.
    n = 0; nv = 0; first_acc = -1; last_acc = -1; first_v = -1; last_v = -1;
    for (int c = 0; c < 30; c++) begin
      addr_vld = {n < 20, 5'b0}; addr_bus[IW*5 +: IW] = IW'(10'h080 + n);
      @(negedge clk);
      if (addr_vld[5] && addr_rdy[5]) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c; n++;
      end
      if (ofm_vld[5]) begin
        if (first_v < 0) first_v = c;
        last_v = c; nv++;
      end
      next_cycle();
    end
    chk("stream.accepts", n, 20);
    chk("stream.acc_span", last_acc - first_acc, 19);
    chk("stream.vld_cycles", nv, 20);
    chk("stream.first_vld", first_v, first_acc + 2);
    chk("stream.vld_span", last_v - first_v, 19);

    // Reset in flight on port 1.
    n = 0; ofm_rdy = '0; addr_bus = '0;
    for (int c = 0; c < 6; c++) begin
      addr_vld = {4'b0, n < 2, 1'b0}; addr_bus[IW*1 +: IW] = IW'(10'h1C0 + n);
      @(negedge clk);
      if (addr_vld[1] && addr_rdy[1]) n++;
      next_cycle();
    end
    addr_vld = 6'h02; addr_bus[IW*1 +: IW] = 10'h1C2;
    @(negedge clk);
    chk("rif.accept", addr_rdy, 6'h02);
    chk("rif.queued", ofm_vld, 6'h02);
    next_cycle();
    rst = 1'b1; addr_vld = '0;
    @(negedge clk);
    chk("rif.rst_rdy", addr_rdy, 0);
    chk("rif.rst_rden", rd_en, 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rif.vld_after%0d", c), ofm_vld, 0);
      next_cycle();
    end
    ofm_rdy = 6'h3F; addr_vld = 6'h02; addr_bus[IW*1 +: IW] = 10'h3A5;
    @(negedge clk);
    chk("post.grant", addr_rdy, 6'h02);
    chk("post.rd_addr", rd_addr, 10'h3A5);
    next_cycle();
    addr_vld = '0;
    @(negedge clk);
    chk("post.vld_t1", ofm_vld, 0);
    next_cycle();
    @(negedge clk);
    chk("post.vld_t2", ofm_vld, 6'h02);
    chk("post.word", ofm[WW*1 +: WW], tag(10'h3A5));
    next_cycle();
    for (int c = 0; c < 3; c++) next_cycle();
    for (int i = 0; i < PC; i++) chk($sformatf("sb.drained%0d", i), q[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
